// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared double-dabble binary-to-BCD converter for two requesters
`timescale 1ns/1ps
module bcd_convert_arbiter #(
  parameter int WIDTH = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      hex0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      hex1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [4*DIGITS-1:0]   bcd0,
  output logic [4*DIGITS-1:0]   bcd1,
  output logic                  ovf0,
  output logic                  ovf1,
  output logic                  busy
);
  localparam int ND = WIDTH * 301 / 1000 + 1;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [4*ND-1:0] acc, adj, acc_n;
  logic [CW-1:0] cnt;
  logic gnt, last, pick, hi;
  assign busy = state != IDLE;
  // on a tie the requester not served last wins
  assign pick = (req0 & req1) ? ~last : req1;
  always_comb begin
    adj = acc;
    for (int i = 0; i < ND; i++)
      adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  assign acc_n = {adj[4*ND-2:0], sr[WIDTH-1]};
  assign hi = |acc_n[4*ND-1:4*DIGITS];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      gnt <= 1'b0;
      last <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      bcd0 <= '0;
      bcd1 <= '0;
      ovf0 <= 1'b0;
      ovf1 <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          gnt <= pick;
          sr <= pick ? hex1 : hex0;
          acc <= '0;
          cnt <= CW'(WIDTH);
          state <= SHIFT;
        end
        SHIFT: begin
          acc <= acc_n;
          sr <= sr << 1;
          cnt <= cnt - 1'b1;
          // the final shift result goes straight to the granted output
          if (cnt == CW'(1)) begin
            state <= DONE;
            if (gnt) begin
              bcd1 <= acc_n[4*DIGITS-1:0];
              ovf1 <= hi;
            end else begin
              bcd0 <= acc_n[4*DIGITS-1:0];
              ovf0 <= hi;
            end
          end
        end
        DONE: begin
          ack0 <= ~gnt;
          ack1 <= gnt;
          last <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: random and directed checks against a transaction-level reference model
`timescale 1ns/1ps
module tb_bcd_convert_arbiter;
  localparam int W = 32;
  localparam int D = 8;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0;
  logic [W-1:0] hex0 = '0, hex1 = '0;
  logic ack0, ack1, ovf0, ovf1, busy;
  logic [4*D-1:0] bcd0, bcd1;
  int vecs = 0, errs = 0, cyc = 0;
  bcd_convert_arbiter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .req0(req0), .hex0(hex0), .req1(req1), .hex1(hex1),
    .ack0(ack0), .ack1(ack1), .bcd0(bcd0), .bcd1(bcd1), .ovf0(ovf0), .ovf1(ovf1), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [4*D:0] to_bcd(input longint unsigned v);
    logic [4*D-1:0] b;
    for (int i = 0; i < D; i++) begin
      b[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return {v != 0, b};
  endfunction
  // model: a grant at edge g writes the result at edge g+W and acks after edge g+W+1
  logic [4*D-1:0] m_bcd0, m_bcd1;
  logic m_ovf0, m_ovf1, m_ack0, m_ack1, m_busy, m_last, m_g;
  logic [W-1:0] m_val;
  logic [4*D:0] r;
  int t = -1;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      {m_bcd0, m_bcd1, m_ovf0, m_ovf1, m_ack0, m_ack1, m_busy} = '0;
      m_last = 1;
      t = -1;
    end else begin
      m_ack0 = 0;
      m_ack1 = 0;
      if (t >= 0) begin
        t++;
        if (t == W) begin
          r = to_bcd(longint'(m_val));
          if (m_g) {m_ovf1, m_bcd1} = r;
          else {m_ovf0, m_bcd0} = r;
        end else if (t == W + 1) begin
          m_ack0 = !m_g;
          m_ack1 = m_g;
          m_last = m_g;
          t = -1;
        end
      end else if (req0 || req1) begin
        m_g = (req0 && req1) ? !m_last : req1;
        m_val = m_g ? hex1 : hex0;
        t = 0;
      end
      m_busy = t >= 0;
    end
  end
  always @(negedge clk) if (cyc > 0) begin
    vecs++;
    if ({ack0, ack1, busy, ovf0, ovf1, bcd0, bcd1} !== {m_ack0, m_ack1, m_busy, m_ovf0, m_ovf1, m_bcd0, m_bcd1}) begin
      errs++;
      $display("FAIL cycle %0d outputs: dut ack=%b%b busy=%b ovf=%b%b bcd0=%h bcd1=%h, model ack=%b%b busy=%b ovf=%b%b bcd0=%h bcd1=%h",
        cyc, ack0, ack1, busy, ovf0, ovf1, bcd0, bcd1, m_ack0, m_ack1, m_busy, m_ovf0, m_ovf1, m_bcd0, m_bcd1);
    end
    vecs++;
    if (ack0 && ack1) begin
      errs++;
      $display("FAIL cycle %0d ack_exclusive: got ack0=%b ack1=%b, need not both", cyc, ack0, ack1);
    end
  end
  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask
  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (ack0 || ack1) at = cyc;
    end
    if (at < 0) begin
      errs++;
      $display("FAIL ack_timeout at cycle %0d: got no ack, expected one within 200 cycles", cyc);
    end
  endtask
  initial begin
    int a, b, t0, prev;
    logic pa;
    check("model_ffffffff", 64'(to_bcd(64'hFFFFFFFF)), {31'd0, 1'b1, 32'h94967295});
    check("model_65535", 64'(to_bcd(64'd65535)), 64'h0000_0000_0006_5535);
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_bcd", {bcd0, bcd1}, 64'd0);
    check("reset_flags", {ack0, ack1, ovf0, ovf1, busy}, 5'd0);
    req0 = 1; hex0 = 32'd65535; t0 = cyc + 1;
    wait_ack(a); req0 = 0;
    check("r31_ack0", ack0, 1);
    check("r31_latency", 64'(a - t0), 64'd33);
    check("r31_bcd0", bcd0, 32'h00065535);
    check("r31_ovf0_bcd1", {ovf0, bcd1}, 33'd0);
    rst = 1; @(negedge clk); rst = 0;
    req0 = 1; req1 = 1; hex0 = 1234; hex1 = 5678;
    wait_ack(a); req0 = 0;
    check("r32_first_ack0", {ack0, ack1}, 2'b10);
    check("r32_bcd0", bcd0, 32'h00001234);
    wait_ack(b); req1 = 0;
    check("r32_second_ack1", {ack0, ack1}, 2'b01);
    check("r32_bcd1", bcd1, 32'h00005678);
    check("r32_spacing", 64'(b - a), 64'd34);
    req1 = 1; hex1 = 32'hFFFFFFFF;
    wait_ack(a); hex1 = 32'd99999999;
    check("r33_bcd1_max", {ovf1, bcd1}, {1'b1, 32'h94967295});
    wait_ack(a); req1 = 0;
    check("r33_bcd1_refresh", {ovf1, bcd1}, {1'b0, 32'h99999999});
    req0 = 1; hex0 = 0;
    repeat (6) @(negedge clk);
    hex0 = 7;
    wait_ack(a); req0 = 0;
    check("r34_bcd0_zero", {ack0, ovf0, bcd0}, {1'b1, 33'd0});
    @(negedge clk);
    check("r34_single_pulse", ack0, 0);
    req0 = 1; req1 = 1;
    wait_ack(prev); pa = ack0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a);
      if (k == 2) begin req0 = 0; req1 = 0; end
      check("r35_alternate", ack0, !pa);
      check("r35_spacing", 64'(a - prev), 64'd34);
      pa = ack0; prev = a;
    end
    req0 = 1; hex0 = 32'd4242;
    @(negedge clk);
    repeat (9) @(negedge clk);
    rst = 1; @(negedge clk);
    check("r36_abort", {busy, ack0, ack1, ovf0, ovf1, bcd0, bcd1}, 69'd0);
    rst = 0; req0 = 0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(499) == 0;
      if (ack0 || $urandom_range(15) == 0) req0 = $urandom_range(2) != 0;
      if (ack1 || $urandom_range(15) == 0) req1 = $urandom_range(2) != 0;
      case ($urandom_range(3))
        0: hex0 = W'($urandom_range(999));
        1: hex0 = $urandom;
        2: hex0 = 32'hFFFFFFFF;
        default: hex0 = 32'd99999998 + W'($urandom_range(3));
      endcase
      hex1 = $urandom_range(1) ? $urandom : W'($urandom_range(100000000));
    end
    rst = 0; req0 = 0; req1 = 0;
    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 8: BCD digits presented on each output (output width 4*DIGITS).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req0  input  1  requester 0 conversion request, level-sensitive.
REQ-006 SHALL have port hex0  input  WIDTH  requester 0 unsigned binary value.
REQ-007 SHALL have port req1  input  1  requester 1 conversion request, level-sensitive.
REQ-008 SHALL have port hex1  input  WIDTH  requester 1 unsigned binary value.
REQ-009 SHALL have port ack0  output  1  one-cycle pulse: bcd0/ovf0 just updated.
REQ-010 SHALL have port ack1  output  1  one-cycle pulse: bcd1/ovf1 just updated.
REQ-011 SHALL have port bcd0  output  4*DIGITS  registered BCD result for requester 0, digit 0 in bits [3:0].
REQ-012 SHALL have port bcd1  output  4*DIGITS  registered BCD result for requester 1.
REQ-013 SHALL have port ovf0  output  1  last requester-0 value exceeded 10^DIGITS-1.
REQ-014 SHALL have port ovf1  output  1  same for requester 1.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL share one iterative shift-and-add-3 (double-dabble) converter between both requesters.
REQ-017 SHALL implement states IDLE, SHIFT, DONE.
REQ-018 IDLE: if any req high at the edge, SHALL grant one requester, capture its hex into the shift register, clear the BCD accumulator, load the bit counter with WIDTH, and go to SHIFT.
REQ-019 Arbitration SHALL be round-robin: on a tie, grant the requester not served last; a single requester is granted immediately.
REQ-020 SHIFT: each cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left one bit, and decrement the counter; after exactly WIDTH shifts, go to DONE.
REQ-021 Internal accumulator SHALL hold floor(WIDTH*301/1000)+1 digits (10 for WIDTH=32), so it never overflows.
REQ-022 On the SHIFT->DONE edge, the SHALL write the low DIGITS digits to the granted bcdX and set ovfX = (any higher digit nonzero); the other requester's outputs remain unchanged.
REQ-023 DONE: ackX of the granted requester SHALL be high for exactly this one cycle, the last-served pointer SHALL be updated, and the next state SHALL be IDLE.
REQ-024 Latency: req sampled at edge E in IDLE -> ack high in the cycle following edge E+WIDTH+1 (33 clocks for WIDTH=32); the next grant is no earlier than the edge ending DONE+1 (IDLE lasts >= 1 cycle).
REQ-025 hex inputs SHALL be sampled only at grant; changes during SHIFT/DONE SHALL NOT affect the result.
REQ-026 req held high after ack SHALL cause another conversion (refresh); requesters drop req on ack for single-shot use.
REQ-027 Requests arriving during SHIFT/DONE SHALL NOT be lost while held; they are arbitrated on the next IDLE cycle.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-029 While rst is high at an edge: state IDLE, bcd0=bcd1=0, ovf0=ovf1=0, ack0=ack1=0, busy=0, last-served pointer = requester 1 (requester 0 wins the first tie).
REQ-030 Reset during SHIFT or DONE SHALL abort the conversion with no ack pulse and no partial result written.

Verification
REQ-031 After reset, req0=1, hex0=32'd65535 -> ack0 33 clocks later, bcd0=32'h00065535, ovf0=0, bcd1 unchanged at 0.
REQ-032 req0 and req1 rise on the same edge, hex0=1234, hex1=5678, each dropped on its ack -> ack0 first with bcd0=32'h00001234, then ack1 34 clocks later with bcd1=32'h00005678.
REQ-033 req1=1, hex1=32'hFFFFFFFF -> bcd1=32'h94967295, ovf1=1; then hex1=32'd99999999 -> bcd1=32'h99999999, ovf1=0.
REQ-034 req0, hex0=0 -> bcd0=0, ovf0=0, ack0 pulses once; then hex0 is changed to 7 mid-SHIFT and the result stays 0.
REQ-035 Both req held high continuously -> acks alternate 0,1,0,1 at 34-clock spacing and never coincide.
REQ-036 rst asserted in the 10th SHIFT cycle -> no ack, busy=0, and all outputs 0 on the following cycle.
